spiker_result_buffer: RTL

SPIKER_RESULT_BUFFER -- requirements
Module: spiker_result_buffer

---
 rtl/spiker_result_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spiker_result_buffer.sv
// Frame FIFO between the spiking core and the software-visible result registers.
// Software sample strobes pop one frame into result_o; sticky flags report drops, underruns and sample-rate wraps.
module spiker_result_buffer #(
  parameter int WIDTH      = 32,
  parameter int N_REG      = 24,
  parameter int DATA_WIDTH = 800,
  parameter int DEPTH      = 4,
  parameter int SAMPLE_DIV = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         sample_i,
  input  logic                         clr_i,
  output logic [N_REG*WIDTH-1:0]       result_o,
  output logic                         result_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         sample_flag_o,
  output logic                         overflow_o,
  output logic                         underrun_o
);

  localparam int RW = N_REG * WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  if (RW > DATA_WIDTH) begin : g_bad_width
    $error("spiker_result_buffer: N_REG*WIDTH exceeds DATA_WIDTH");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("spiker_result_buffer: DEPTH must be a power of two >= 2");
  end
  if (SAMPLE_DIV < 1) begin : g_bad_div
    $error("spiker_result_buffer: SAMPLE_DIV must be >= 1");
  end

  // Spike bits above the register image are intentionally dropped.
  if (RW < DATA_WIDTH) begin : g_unused_hi
    logic unused_hi_s;
    assign unused_hi_s = ^data_i[DATA_WIDTH-1:RW];
  end

  logic [RW-1:0] mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [LW-1:0] level_r;
  logic [CW-1:0] cnt_r;
  logic [RW-1:0] result_r;
  logic          result_valid_r;
  logic          sample_flag_r;
  logic          overflow_r;
  logic          underrun_r;

  logic          ready_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic          under_s;
  logic          wrap_s;
  logic [LW-1:0] level_nxt_s;
  logic [CW-1:0] cnt_nxt_s;

  // Handshake decode and next-state values for level and sample counter.
  always_comb begin
    ready_s     = (level_r < LVL_FULL);
    push_s      = valid_i & ready_s;
    drop_s      = valid_i & ~ready_s;
    pop_s       = sample_i & (level_r != LW'(0));
    under_s     = sample_i & (level_r == LW'(0));
    wrap_s      = sample_i & (cnt_r == CNT_LAST);
    level_nxt_s = level_r;
    cnt_nxt_s   = cnt_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
    if (!sample_i) begin
      cnt_nxt_s = cnt_r;
    end else if (wrap_s) begin
      cnt_nxt_s = CW'(0);
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // Frame storage; contents need no reset since level gates every read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_s) begin
      mem_r[tail_r] <= data_i[RW-1:0];
    end
  end

  // Pointers, level, result register, counter and sticky flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_r         <= PW'(0);
      tail_r         <= PW'(0);
      level_r        <= LW'(0);
      cnt_r          <= CW'(0);
      result_r       <= RW'(0);
      result_valid_r <= 1'b0;
      sample_flag_r  <= 1'b0;
      overflow_r     <= 1'b0;
      underrun_r     <= 1'b0;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PW'(1);
      end
      // Pop reads the pre-existing head, so a same-cycle push never bypasses.
      if (pop_s) begin
        result_r <= mem_r[head_r];
        head_r   <= head_r + PW'(1);
      end
      level_r        <= level_nxt_s;
      cnt_r          <= cnt_nxt_s;
      result_valid_r <= pop_s;
      sample_flag_r  <= wrap_s  | (sample_flag_r & ~clr_i);
      overflow_r     <= drop_s  | (overflow_r & ~clr_i);
      underrun_r     <= under_s | (underrun_r & ~clr_i);
    end
  end

  assign ready_o        = ready_s;
  assign result_o       = result_r;
  assign result_valid_o = result_valid_r;
  assign level_o        = level_r;
  assign sample_flag_o  = sample_flag_r;
  assign overflow_o     = overflow_r;
  assign underrun_o     = underrun_r;

endmodule
